mmss_stopwatch: RTL and testbench

- Upstream stage of the 8-digit seven-segment scan/display controller.
- Produces the two 0–99 binary values that the display controller splits into tens/units digits: minutes and seconds.
- Implements a start/pause/clear stopwatch driven by two raw push-buttons.
- Includes a 1 Hz prescaler, button synchronisation and debounce, and a run-control FSM.

---
 rtl/mmss_stopwatch_pkg.sv | 26 ++
 rtl/mmss_stopwatch_btn_debounce.sv | 68 ++++++
 rtl/mmss_stopwatch.sv | 151 +++++++++++++++
 tb/tb_mmss_stopwatch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mmss_stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// mmss_stopwatch_pkg
// Shared timer definitions for the minutes/seconds stopwatch:
//   - run-control FSM state encodings
//   - saturation limits for the minutes and seconds counts
//   - helper that recognises the terminal 99:59 count
// No ports (package).
// ---------------------------------------------------------------------------
package mmss_stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [6:0] MAX_SEC = 7'd59;

  // True when the count sits at 99:59, i.e. the next tick must saturate.
  function automatic logic is_terminal(input logic [6:0] mins, input logic [6:0] secs);
    return (mins == MAX_MIN) && (secs == MAX_SEC);
  endfunction

endpackage

// File: rtl/mmss_stopwatch_btn_debounce.sv
// ---------------------------------------------------------------------------
// mmss_stopwatch_btn_debounce
// Push-button conditioner: 2-flop synchroniser, stable-level debounce
// counter and a one-cycle press pulse on the debounced rising edge.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   btn_raw in   raw active-high button, asynchronous to clk
//   level   out  debounced button level
//   press   out  one-cycle pulse, registered, on debounced 0->1 edge
// Latency from raw rise to press high: 2 + DB_CYCLES + 1 clocks.
// ---------------------------------------------------------------------------
module mmss_stopwatch_btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_prev_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg      <= 1'b0;
      sync2_reg      <= 1'b0;
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      press_reg      <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;

      // The counter only advances while the synchronised input disagrees
      // with the accepted level; any agreement restarts the window. The
      // level flips on the DB_CYCLES-th consecutive disagreeing cycle.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CNT_LAST) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end

      // Edge detect one cycle behind the level so the pulse is a clean flop.
      level_prev_reg <= level_reg;
      press_reg      <= level_reg & ~level_prev_reg;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/mmss_stopwatch.sv
// ---------------------------------------------------------------------------
// mmss_stopwatch
// Start/pause/clear stopwatch feeding the seven-segment display controller
// with binary minutes (0..99) and seconds (0..59).
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   btn_start  in   raw start/pause button (active-high, async)
//   btn_clear  in   raw clear button (active-high, async)
//   num_min    out  minutes 0..99, registered
//   num_sec    out  seconds 0..59, registered
//   running    out  high while in RUN, registered
//   full       out  high while saturated at 99:59 (FULL), registered
// ---------------------------------------------------------------------------
module mmss_stopwatch
  import mmss_stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [6:0] num_min,
  output logic [6:0] num_sec,
  output logic       running,
  output logic       full
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_press;
  logic clear_press;
  logic start_level;
  logic clear_level;

  mmss_stopwatch_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_start),
    .level   (start_level),
    .press   (start_press)
  );

  mmss_stopwatch_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clear),
    .level   (clear_level),
    .press   (clear_press)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  logic unused_levels;
  assign unused_levels = start_level ^ clear_level;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [6:0]    min_reg;
  logic [6:0]    sec_reg;
  logic          running_reg;
  logic          full_reg;
  logic          tick;

  assign tick = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);

  // Priority: clear > tick > start. running/full are written alongside the
  // state so they always change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      presc_reg   <= '0;
      min_reg     <= '0;
      sec_reg     <= '0;
      running_reg <= 1'b0;
      full_reg    <= 1'b0;
    end else if (clear_press) begin
      state_reg   <= ST_IDLE;
      presc_reg   <= '0;
      min_reg     <= '0;
      sec_reg     <= '0;
      running_reg <= 1'b0;
      full_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          presc_reg <= '0;
          if (start_press) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end

        ST_RUN: begin
          if (tick) begin
            presc_reg <= '0;
            if (is_terminal(min_reg, sec_reg)) begin
              // Saturate: counts hold at 99:59, a same-cycle start is dropped.
              state_reg   <= ST_FULL;
              running_reg <= 1'b0;
              full_reg    <= 1'b1;
            end else begin
              if (sec_reg == MAX_SEC) begin
                sec_reg <= '0;
                min_reg <= min_reg + 7'd1;
              end else begin
                sec_reg <= sec_reg + 7'd1;
              end
              if (start_press) begin
                state_reg   <= ST_PAUSE;
                running_reg <= 1'b0;
              end
            end
          end else begin
            presc_reg <= presc_reg + PW'(1);
            if (start_press) begin
              state_reg   <= ST_PAUSE;
              running_reg <= 1'b0;
            end
          end
        end

        ST_PAUSE: begin
          // Prescaler holds so a resume finishes the interrupted second.
          if (start_press) begin
            state_reg   <= ST_RUN;
            running_reg <= 1'b1;
          end
        end

        ST_FULL: begin
          presc_reg <= '0;
        end

        default: begin
          state_reg   <= ST_IDLE;
          running_reg <= 1'b0;
          full_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign num_min = min_reg;
  assign num_sec = sec_reg;
  assign running = running_reg;
  assign full    = full_reg;

endmodule

// File: tb/tb_mmss_stopwatch.sv
// ---------------------------------------------------------------------------
// tb_mmss_stopwatch
// Directed bench for mmss_stopwatch with TICK_DIV=10, DB_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// Timeline notes use E = edge right before the raw button rose:
//   press pulse visible after E+7, state/running change at E+8.
// ---------------------------------------------------------------------------
module tb_mmss_stopwatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start;
  logic       btn_clear;
  logic [6:0] num_min;
  logic [6:0] num_sec;
  logic       running;
  logic       full;

  int n_cmp = 0;
  int n_bad = 0;

  mmss_stopwatch #(.TICK_DIV(10), .DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .num_min   (num_min),
    .num_sec   (num_sec),
    .running   (running),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
    step(2);
    n_cmp++; if (num_min !== 7'd0) begin n_bad++; $display("FAIL rst_min got %0d want 0", num_min); end
    n_cmp++; if (num_sec !== 7'd0) begin n_bad++; $display("FAIL rst_sec got %0d want 0", num_sec); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL rst_running got %b want 0", running); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", full); end
    rst_n = 1'b1;
    step(50);
    n_cmp++; if (num_sec !== 7'd0) begin n_bad++; $display("FAIL idle_sec got %0d want 0", num_sec); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL idle_running got %b want 0", running); end
    // 3-cycle glitches are shorter than the debounce window.
    btn_start = 1'b1; step(3); btn_start = 1'b0; step(3);
    btn_clear = 1'b1; step(3); btn_clear = 1'b0; step(20);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL glitch_running got %b want 0", running); end
    n_cmp++; if (num_sec !== 7'd0 || full !== 1'b0) begin n_bad++; $display("FAIL glitch_state got sec=%0d full=%b want 0/0", num_sec, full); end
    $display("test_reset done: %0d compared", n_cmp);
  endtask

  task automatic test_start();
    btn_start = 1'b1;                 // rise after E
    step(7);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL start_early got %b want 0 at E+7", running); end
    step(1);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_latency got %b want 1 at E+8", running); end
    step(2); btn_start = 1'b0;        // held 10 cycles
    step(7);
    n_cmp++; if (num_sec !== 7'd0) begin n_bad++; $display("FAIL sec_before_tick got %0d want 0", num_sec); end
    step(1);
    n_cmp++; if (num_sec !== 7'd1 || num_min !== 7'd0) begin n_bad++; $display("FAIL first_tick got %0d:%0d want 0:1", num_min, num_sec); end
    step(589);
    n_cmp++; if (num_min !== 7'd0 || num_sec !== 7'd59) begin n_bad++; $display("FAIL pre_minute got %0d:%0d want 0:59", num_min, num_sec); end
    step(1);
    n_cmp++; if (num_min !== 7'd1 || num_sec !== 7'd0 || running !== 1'b1) begin n_bad++; $display("FAIL minute_roll got %0d:%0d r=%b want 1:0 r=1", num_min, num_sec, running); end
    $display("test_start done: %0d compared", n_cmp);
  endtask

  // Entered with 01:00 and prescaler just wrapped to 0 (R').
  task automatic test_pause_resume();
    step(48); btn_start = 1'b1;       // T = R'+48, pause edge R'+56 leaves prescaler at 6
    step(7);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL pause_early got %b want 1", running); end
    step(1);
    n_cmp++; if (running !== 1'b0 || num_min !== 7'd1 || num_sec !== 7'd5) begin n_bad++; $display("FAIL pause_enter got %0d:%0d r=%b want 1:5 r=0", num_min, num_sec, running); end
    step(2); btn_start = 1'b0;
    step(100);
    n_cmp++; if (running !== 1'b0 || num_min !== 7'd1 || num_sec !== 7'd5) begin n_bad++; $display("FAIL pause_hold got %0d:%0d r=%b want 1:5 r=0", num_min, num_sec, running); end
    btn_start = 1'b1;                 // U
    step(8);
    n_cmp++; if (running !== 1'b1 || num_sec !== 7'd5) begin n_bad++; $display("FAIL resume got sec=%0d r=%b want 5 r=1", num_sec, running); end
    step(2); btn_start = 1'b0;
    step(1);
    n_cmp++; if (num_sec !== 7'd5) begin n_bad++; $display("FAIL resume_3cyc got %0d want 5", num_sec); end
    step(1);
    n_cmp++; if (num_sec !== 7'd6 || num_min !== 7'd1) begin n_bad++; $display("FAIL resume_4cyc got %0d:%0d want 1:6", num_min, num_sec); end
    $display("test_pause_resume done: %0d compared", n_cmp);
  endtask

  // Entered at 01:06 with prescaler 0; runs up to saturation.
  task automatic test_full();
    step(59329);
    n_cmp++; if (num_min !== 7'd99 || num_sec !== 7'd58 || full !== 1'b0) begin n_bad++; $display("FAIL at_9958 got %0d:%0d full=%b want 99:58 full=0", num_min, num_sec, full); end
    step(1);
    n_cmp++; if (num_min !== 7'd99 || num_sec !== 7'd59 || full !== 1'b0 || running !== 1'b1) begin n_bad++; $display("FAIL at_9959 got %0d:%0d f=%b r=%b want 99:59 f=0 r=1", num_min, num_sec, full, running); end
    step(9);
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_early got %b want 0", full); end
    step(1);
    n_cmp++; if (full !== 1'b1 || running !== 1'b0 || num_min !== 7'd99 || num_sec !== 7'd59) begin n_bad++; $display("FAIL full_enter got %0d:%0d f=%b r=%b want 99:59 f=1 r=0", num_min, num_sec, full, running); end
    for (int i = 0; i < 2; i++) begin
      btn_start = 1'b1; step(10); btn_start = 1'b0; step(20);
      n_cmp++; if (full !== 1'b1 || running !== 1'b0 || num_min !== 7'd99 || num_sec !== 7'd59) begin n_bad++; $display("FAIL full_start%0d got %0d:%0d f=%b r=%b want 99:59 f=1 r=0", i, num_min, num_sec, full, running); end
    end
    $display("test_full done: %0d compared", n_cmp);
  endtask

  task automatic test_clear();
    btn_clear = 1'b1;
    step(7);
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL clear_early got %b want 1", full); end
    step(1);
    n_cmp++; if (full !== 1'b0 || running !== 1'b0 || num_min !== 7'd0 || num_sec !== 7'd0) begin n_bad++; $display("FAIL clear_full got %0d:%0d f=%b r=%b want 0:0 f=0 r=0", num_min, num_sec, full, running); end
    step(2); btn_clear = 1'b0;
    step(20);
    n_cmp++; if (num_sec !== 7'd0 || running !== 1'b0) begin n_bad++; $display("FAIL clear_idle got sec=%0d r=%b want 0 r=0", num_sec, running); end
    $display("test_clear done: %0d compared", n_cmp);
  endtask

  // Start and clear debounced on the same cycle, which is also a tick edge.
  task automatic test_clear_vs_start();
    btn_start = 1'b1;                 // S
    step(8);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL cvs_run got %b want 1", running); end
    step(2); btn_start = 1'b0;
    step(20);
    n_cmp++; if (num_sec !== 7'd2) begin n_bad++; $display("FAIL cvs_count got %0d want 2", num_sec); end
    btn_start = 1'b1; btn_clear = 1'b1;   // V = S+30, action edge S+38
    step(7);
    n_cmp++; if (running !== 1'b1 || num_sec !== 7'd2) begin n_bad++; $display("FAIL cvs_before got sec=%0d r=%b want 2 r=1", num_sec, running); end
    step(1);
    n_cmp++; if (running !== 1'b0 || num_sec !== 7'd0 || num_min !== 7'd0 || full !== 1'b0) begin n_bad++; $display("FAIL cvs_clear got %0d:%0d r=%b f=%b want 0:0 r=0 f=0", num_min, num_sec, running, full); end
    step(2); btn_start = 1'b0; btn_clear = 1'b0;
    step(20);
    n_cmp++; if (running !== 1'b0 || num_sec !== 7'd0) begin n_bad++; $display("FAIL cvs_idle got sec=%0d r=%b want 0 r=0", num_sec, running); end
    $display("test_clear_vs_start done: %0d compared", n_cmp);
  endtask

  task automatic test_reset_mid();
    btn_start = 1'b1;                 // W
    step(8);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL mid_run got %b want 1", running); end
    step(2); btn_start = 1'b0;
    step(7538);                       // X = W+7548
    n_cmp++; if (num_min !== 7'd12 || num_sec !== 7'd34 || running !== 1'b1) begin n_bad++; $display("FAIL at_1234 got %0d:%0d r=%b want 12:34 r=1", num_min, num_sec, running); end
    rst_n = 1'b0; btn_start = 1'b1;
    step(1);
    rst_n = 1'b1;
    n_cmp++; if (num_min !== 7'd0 || num_sec !== 7'd0 || running !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL mid_reset got %0d:%0d r=%b f=%b want 0:0 r=0 f=0", num_min, num_sec, running, full); end
    step(7);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL post_rst_early got %b want 0", running); end
    step(1);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL post_rst_start got %b want 1", running); end
    step(9);
    n_cmp++; if (num_sec !== 7'd0) begin n_bad++; $display("FAIL post_rst_presc got %0d want 0", num_sec); end
    step(1);
    n_cmp++; if (num_sec !== 7'd1) begin n_bad++; $display("FAIL post_rst_tick got %0d want 1", num_sec); end
    btn_start = 1'b0;
    $display("test_reset_mid done: %0d compared", n_cmp);
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_full();
    test_clear();
    test_clear_vs_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
